// File: rtl/adder_pkg.sv
// Shared definitions for the adder checker and the adder's own benches:
// checker state encoding and the reference add/subtract result model.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Widest operand the reference model handles; callers cast down to BIT+1.
    localparam int MAX_BIT = 16;

    // Returns {cout, SUM} in the low bits+1 bits. Subtract is A + ~B + 1, so
    // cout=1 means no borrow.
    function automatic logic [MAX_BIT:0] adder_expected(
        input logic               addsub,
        input logic [MAX_BIT-1:0] a,
        input logic [MAX_BIT-1:0] b,
        input int                 bits
    );
        logic [MAX_BIT:0] mask_op;
        logic [MAX_BIT:0] mask_res;
        logic [MAX_BIT:0] b_eff;
        logic [MAX_BIT:0] res;
        mask_op  = ((MAX_BIT+1)'(1) << bits) - (MAX_BIT+1)'(1);
        mask_res = ((MAX_BIT+1)'(1) << (bits + 1)) - (MAX_BIT+1)'(1);
        b_eff    = addsub ? (~{1'b0, b} & mask_op) : ({1'b0, b} & mask_op);
        res      = ({1'b0, a} & mask_op) + b_eff + {{MAX_BIT{1'b0}}, addsub};
        return res & mask_res;
    endfunction

endpackage

// File: rtl/adder_exp_pipe.sv
// LAT-deep valid/data shift register carrying expected results alongside
// the adder's own pipeline; clr empties every stage on the next edge.
module adder_exp_pipe #(
    parameter int LAT = 1,
    parameter int W   = 8
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         clr,
    input  logic         en,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic         valid_reg [LAT];
    logic [W-1:0] data_reg  [LAT];
    logic         valid_next [LAT];
    logic [W-1:0] data_next  [LAT];

    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign valid_next[gi] = in_valid;
                assign data_next[gi]  = in_data;
            end else begin : g_body
                assign valid_next[gi] = valid_reg[gi-1];
                assign data_next[gi]  = data_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < LAT; i++) begin
                valid_reg[i] <= 1'b0;
                data_reg[i]  <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < LAT; i++) begin
                valid_reg[i] <= 1'b0;
                data_reg[i]  <= '0;
            end
        end else if (en) begin
            for (int i = 0; i < LAT; i++) begin
                valid_reg[i] <= valid_next[i];
                data_reg[i]  <= data_next[i];
            end
        end
    end

    assign out_valid = valid_reg[LAT-1];
    assign out_data  = data_reg[LAT-1];

endmodule

// File: rtl/adder_seq_checker.sv
// Sweeps every {addsub, A, B} vector into a registered adder, compares each
// result LAT edges later against the reference model, and counts mismatches.
module adder_seq_checker
    import adder_pkg::*;
#(
    parameter int BIT = 3,
    parameter int LAT = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    output logic             addsub,
    output logic [BIT-1:0]   A,
    output logic [BIT-1:0]   B,
    input  logic [BIT-1:0]   SUM,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [2*BIT+1:0] err_count,
    output logic [2*BIT:0]   first_err_vec
);

    localparam int VW = 2*BIT + 1;
    localparam int DW = BIT + 1 + VW;
    localparam int CW = $clog2(LAT + 1);
    localparam logic [VW-1:0] V_LAST = '1;

    state_t            state_reg, state_next;
    logic [VW-1:0]     vec_reg;
    logic [CW-1:0]     drain_reg;
    logic [2*BIT+1:0]  err_reg;
    logic [VW-1:0]     first_reg;

    logic              enter_drive;
    logic              pipe_en;
    logic              pipe_in_valid;
    logic [BIT:0]      exp_res;
    logic              pipe_out_valid;
    logic [DW-1:0]     pipe_out_data;
    logic [BIT:0]      stage_exp;
    logic [VW-1:0]     stage_vec;
    logic              mismatch;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next    = state_reg;
        enter_drive   = 1'b0;
        pipe_en       = 1'b0;
        pipe_in_valid = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next  = DRIVE;
                    enter_drive = 1'b1;
                end
            end
            DRIVE: begin
                pipe_en       = 1'b1;
                pipe_in_valid = 1'b1;
                if (vec_reg == V_LAST) state_next = DRAIN;
            end
            DRAIN: begin
                pipe_en = 1'b1;
                if (drain_reg == CW'(LAT - 1)) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The vector register doubles as the operand outputs; it parks on all
    // ones after the sweep so DRAIN and DONE keep driving the last vector.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vec_reg   <= '0;
            drain_reg <= '0;
        end else begin
            if (enter_drive)
                vec_reg <= '0;
            else if (state_reg == DRIVE && vec_reg != V_LAST)
                vec_reg <= vec_reg + VW'(1);
            if (state_reg == DRAIN) drain_reg <= drain_reg + CW'(1);
            else                    drain_reg <= '0;
        end
    end

    assign exp_res = (BIT+1)'(adder_expected(vec_reg[VW-1],
                                             MAX_BIT'(vec_reg[VW-2:BIT]),
                                             MAX_BIT'(vec_reg[BIT-1:0]),
                                             BIT));

    adder_exp_pipe #(
        .LAT (LAT),
        .W   (DW)
    ) u_exp_pipe (
        .clk       (clk),
        .nrst      (nrst),
        .clr       (enter_drive),
        .en        (pipe_en),
        .in_valid  (pipe_in_valid),
        .in_data   ({exp_res, vec_reg}),
        .out_valid (pipe_out_valid),
        .out_data  (pipe_out_data)
    );

    assign stage_exp = pipe_out_data[DW-1:VW];
    assign stage_vec = pipe_out_data[VW-1:0];
    assign mismatch  = pipe_en && pipe_out_valid && ({cout, SUM} != stage_exp);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            err_reg   <= '0;
            first_reg <= '0;
        end else if (enter_drive) begin
            err_reg   <= '0;
            first_reg <= '0;
        end else if (mismatch) begin
            err_reg <= err_reg + (2*BIT+2)'(1);
            if (err_reg == '0) first_reg <= stage_vec;
        end
    end

    assign addsub        = vec_reg[VW-1];
    assign A             = vec_reg[VW-2:BIT];
    assign B             = vec_reg[BIT-1:0];
    assign busy          = (state_reg == DRIVE) || (state_reg == DRAIN);
    assign done          = (state_reg == DONE);
    assign pass          = done && (err_reg == '0);
    assign err_count     = err_reg;
    assign first_err_vec = first_reg;

endmodule

// File: tb/tb_adder_seq_checker.sv
// Bench: two checkers (LAT=1 and LAT=2) each driving a 1-cycle adder model
// whose outputs can be corrupted to provoke known mismatch counts.
module tb_adder_seq_checker;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       start1 = 1'b0;
    logic       start2 = 1'b0;
    int         fault = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    logic       addsub1, addsub2;
    logic [2:0] a1, b1, a2, b2;
    logic [2:0] sum1, sum2;
    logic       cout1, cout2;
    logic       busy1, busy2, done1, done2, pass1, pass2;
    logic [7:0] err1, err2;
    logic [6:0] first1, first2;
    logic [3:0] add1_q, add2_q;

    always #5 clk = ~clk;

    function automatic logic [3:0] model_add(input logic s, input logic [2:0] a, input logic [2:0] b);
        logic [2:0] nb;
        nb = ~b;
        if (s) return {1'b0, a} + {1'b0, nb} + 4'd1;
        return {1'b0, a} + {1'b0, b};
    endfunction

    always @(posedge clk) begin
        add1_q <= model_add(addsub1, a1, b1);
        add2_q <= model_add(addsub2, a2, b2);
    end

    assign sum1  = (fault == 1) ? {add1_q[2:1], 1'b0} : add1_q[2:0];
    assign cout1 = (fault == 2) ? 1'b0 : add1_q[3];
    assign sum2  = add2_q[2:0];
    assign cout2 = add2_q[3];

    adder_seq_checker #(.BIT(3), .LAT(1)) dut (
        .clk(clk), .nrst(nrst), .start(start1), .addsub(addsub1), .A(a1), .B(b1),
        .SUM(sum1), .cout(cout1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_err_vec(first1)
    );

    adder_seq_checker #(.BIT(3), .LAT(2)) dut2 (
        .clk(clk), .nrst(nrst), .start(start2), .addsub(addsub2), .A(a2), .B(b2),
        .SUM(sum2), .cout(cout2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_err_vec(first2)
    );

    // One start pulse; returns #1 after edge 0.
    task automatic kick(input int sel);
        if (sel == 0) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // Counts edges after edge 0 until done is seen; -1 if the bound expires.
    task automatic wait_done(input int sel, input int pulse_at, output int n);
        n = -1;
        for (int i = 1; i <= 400; i++) begin
            if (i == pulse_at) start1 = 1'b1;
            @(posedge clk); #1;
            if (i == pulse_at) start1 = 1'b0;
            if ((sel == 0 && done1) || (sel == 1 && done2)) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic test_reset;
        nrst = 1'b0;
        #3;
        n_checks++;
        if ({addsub1, a1, b1, busy1, done1, pass1, err1, first1} !== 25'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h required 0", {addsub1, a1, b1, busy1, done1, pass1, err1, first1});
        end
        @(negedge clk) nrst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: busy=%b done=%b required 0/0", busy1, done1);
        end
        $display("test_reset: idle after reset");
    endtask

    task automatic test_clean;
        int n;
        kick(0);
        n_checks++;
        if (busy1 !== 1'b1 || {addsub1, a1, b1} !== 7'd0) begin
            n_errors++;
            $display("FAIL clean_edge0: busy=%b vec=%0d required 1/0", busy1, {addsub1, a1, b1});
        end
        wait_done(0, 0, n);
        n_checks++;
        if (n !== 129) begin
            n_errors++;
            $display("FAIL clean_done_edge: got %0d required 129", n);
        end
        n_checks++;
        if (err1 !== 8'd0 || pass1 !== 1'b1 || busy1 !== 1'b0) begin
            n_errors++;
            $display("FAIL clean_result: err=%0d pass=%b busy=%b required 0/1/0", err1, pass1, busy1);
        end
        n_checks++;
        if (a1 !== 3'd7 || b1 !== 3'd7 || addsub1 !== 1'b1) begin
            n_errors++;
            $display("FAIL clean_last_vec: A=%0d B=%0d addsub=%b required 7/7/1", a1, b1, addsub1);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done1 !== 1'b1) begin
            n_errors++;
            $display("FAIL clean_done_hold: got %b required 1", done1);
        end
        $display("test_clean: done at edge %0d err=%0d pass=%b", n, err1, pass1);
    endtask

    task automatic test_sum_fault;
        int n;
        fault = 1;
        kick(0);
        wait_done(0, 0, n);
        n_checks++;
        if (n !== 129 || err1 !== 8'd64 || first1 !== 7'd1 || pass1 !== 1'b0) begin
            n_errors++;
            $display("FAIL sum_fault: edge=%0d err=%0d first=%0d pass=%b required 129/64/1/0", n, err1, first1, pass1);
        end
        fault = 0;
        $display("test_sum_fault: err=%0d first=%0d", err1, first1);
    endtask

    task automatic test_cout_fault;
        int n;
        fault = 2;
        kick(0);
        wait_done(0, 0, n);
        n_checks++;
        if (err1 !== 8'd64 || first1 !== 7'd15 || pass1 !== 1'b0) begin
            n_errors++;
            $display("FAIL cout_fault: err=%0d first=%0d pass=%b required 64/15/0", err1, first1, pass1);
        end
        fault = 0;
        $display("test_cout_fault: err=%0d first=%0d", err1, first1);
    endtask

    task automatic test_reset_mid_drive;
        int n;
        fault = 1;
        kick(0);
        repeat (40) @(posedge clk);
        #1;
        // Vector 40 = {0,5,0}; compares of vectors 0..38 done, 19 have odd sums.
        n_checks++;
        if (a1 !== 3'd5 || b1 !== 3'd0 || err1 !== 8'd19 || first1 !== 7'd1) begin
            n_errors++;
            $display("FAIL mid_drive_state: A=%0d B=%0d err=%0d first=%0d required 5/0/19/1", a1, b1, err1, first1);
        end
        #2 nrst = 1'b0;
        #1;
        n_checks++;
        if ({addsub1, a1, b1, busy1, done1, pass1, err1, first1} !== 25'd0) begin
            n_errors++;
            $display("FAIL async_reset: got %h required 0", {addsub1, a1, b1, busy1, done1, pass1, err1, first1});
        end
        @(negedge clk) nrst = 1'b1;
        fault = 0;
        @(posedge clk); #1;
        kick(0);
        wait_done(0, 0, n);
        n_checks++;
        if (n !== 129 || err1 !== 8'd0 || pass1 !== 1'b1) begin
            n_errors++;
            $display("FAIL rerun_after_reset: edge=%0d err=%0d pass=%b required 129/0/1", n, err1, pass1);
        end
        $display("test_reset_mid_drive: rerun done at edge %0d err=%0d", n, err1);
    endtask

    task automatic test_ignore_start;
        int n;
        kick(0);
        wait_done(0, 50, n);
        n_checks++;
        if (n !== 129 || pass1 !== 1'b1) begin
            n_errors++;
            $display("FAIL ignore_start: edge=%0d pass=%b required 129/1", n, pass1);
        end
        $display("test_ignore_start: done at edge %0d", n);
    endtask

    task automatic test_back_to_back;
        int n;
        fault = 1;
        start1 = 1'b1;
        @(posedge clk); #1;
        wait_done(0, 0, n);
        n_checks++;
        if (n !== 129 || err1 !== 8'd64) begin
            n_errors++;
            $display("FAIL b2b_first: edge=%0d err=%0d required 129/64", n, err1);
        end
        fault = 0;
        @(posedge clk); #1;
        start1 = 1'b0;
        n_checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b1 || err1 !== 8'd0) begin
            n_errors++;
            $display("FAIL b2b_restart: done=%b busy=%b err=%0d required 0/1/0", done1, busy1, err1);
        end
        wait_done(0, 0, n);
        n_checks++;
        if (n !== 129 || err1 !== 8'd0 || pass1 !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_second: edge=%0d err=%0d pass=%b required 129/0/1", n, err1, pass1);
        end
        $display("test_back_to_back: second sweep err=%0d pass=%b", err1, pass1);
    endtask

    task automatic test_lat_mismatch;
        int n;
        kick(1);
        wait_done(1, 0, n);
        n_checks++;
        if (n !== 130) begin
            n_errors++;
            $display("FAIL lat2_done_edge: got %0d required 130", n);
        end
        n_checks++;
        if (err2 == 8'd0 || pass2 !== 1'b0 || first2 !== 7'd0) begin
            n_errors++;
            $display("FAIL lat2_result: err=%0d pass=%b first=%0d required nonzero/0/0", err2, pass2, first2);
        end
        $display("test_lat_mismatch: done at edge %0d err=%0d", n, err2);
    endtask

    initial begin
        test_reset();
        test_clean();
        test_sum_fault();
        test_cout_fault();
        test_reset_mid_drive();
        test_ignore_start();
        test_back_to_back();
        test_lat_mismatch();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
